// File: rtl/cnn_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and the four layer engines.
// master = sequencer side, slave = engine/host side.
interface cnn_layer_sequencer_if;
  logic       enable;
  logic       abort;
  logic       conv_start;
  logic       conv_done;
  logic       relu_start;
  logic       relu_done;
  logic       pool_start;
  logic       pool_done;
  logic       fc_start;
  logic       fc_done;
  logic [3:0] fc_class;
  logic [3:0] result;
  logic       result_valid;
  logic       busy;
  logic [1:0] stage;
  logic       timeout_err;

  modport master (
    input  enable, abort, conv_done, relu_done, pool_done, fc_done, fc_class,
    output conv_start, relu_start, pool_start, fc_start, result, result_valid, busy, stage,
           timeout_err
  );

  modport slave (
    output enable, abort, conv_done, relu_done, pool_done, fc_done, fc_class,
    input  conv_start, relu_start, pool_start, fc_start, result, result_valid, busy, stage,
           timeout_err
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Runs conv, ReLU, pool and FC engines in order with a per-layer watchdog,
// then holds the FC class index until enable drops.
module cnn_layer_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input logic                    clk,
  input logic                    rst,
  cnn_layer_sequencer_if.master  bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StError} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       stage_q;
  logic [3:0]       result_q;
  logic [3:0]       start_q;
  logic             busy_q;
  logic             valid_q;
  logic             err_q;

  logic [3:0] done_vec;
  logic       cur_done;

  // Only the engine of the current stage may advance the sequence.
  assign done_vec = {bus.fc_done, bus.pool_done, bus.relu_done, bus.conv_done};
  assign cur_done = done_vec[stage_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      stage_q  <= 2'd0;
      result_q <= 4'd0;
      start_q  <= 4'd0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= 4'd0;
      unique case (state_q)
        StIdle: begin
          if (bus.enable) begin
            state_q  <= StIssue;
            stage_q  <= 2'd0;
            result_q <= 4'd0;
            start_q  <= 4'b0001;
            busy_q   <= 1'b1;
          end
        end
        StIssue: begin
          cnt_q <= '0;
          if (bus.abort) begin
            state_q <= StIdle;
            stage_q <= 2'd0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus.abort) begin
            state_q <= StIdle;
            stage_q <= 2'd0;
            busy_q  <= 1'b0;
          end else if (cur_done) begin
            if (stage_q != 2'd3) begin
              state_q <= StIssue;
              stage_q <= stage_q + 2'd1;
              start_q <= 4'b0001 << (stage_q + 2'd1);
            end else begin
              state_q  <= StDone;
              result_q <= bus.fc_class;
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= StError;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          // Held enable does not retrigger; a low cycle is needed first.
          if (!bus.enable) begin
            state_q <= StIdle;
            stage_q <= 2'd0;
            valid_q <= 1'b0;
          end
        end
        StError: begin
          if (!bus.enable) begin
            state_q <= StIdle;
            stage_q <= 2'd0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.conv_start   = start_q[0];
  assign bus.relu_start   = start_q[1];
  assign bus.pool_start   = start_q[2];
  assign bus.fc_start     = start_q[3];
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.stage        = stage_q;
  assign bus.timeout_err  = err_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer with a 16-cycle watchdog.
module tb_cnn_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] done_v = 4'd0;  // {fc, pool, relu, conv}
  logic [3:0] r_exp = 4'd0;
  int         checks = 0;
  int         errors = 0;

  cnn_layer_sequencer_if bus ();

  assign bus.conv_done = done_v[0];
  assign bus.relu_done = done_v[1];
  assign bus.pool_done = done_v[2];
  assign bus.fc_done   = done_v[3];

  cnn_layer_sequencer #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // st = {conv, relu, pool, fc} start pulses.
  task automatic chk(input string tag, input logic [3:0] st, input logic b, input logic rv,
                     input logic te, input logic [1:0] sg, input logic [3:0] rs);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {bus.conv_start, bus.relu_start, bus.pool_start, bus.fc_start, bus.busy,
           bus.result_valid, bus.timeout_err, bus.stage, bus.result};
    exp = {st, b, rv, te, sg, rs};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Entered right after the edge into ISSUE of stage s; leaves right after
  // the edge that samples this stage's done, extra WAIT cycles first.
  task automatic stage_step(input int s, input int extra);
    logic [3:0] one;
    one = 4'b1000;
    chk("issue", one >> s, 1'b1, 1'b0, 1'b0, 2'(s), r_exp);
    tick();
    chk("wait", 4'd0, 1'b1, 1'b0, 1'b0, 2'(s), r_exp);
    repeat (extra) tick();
    done_v = 4'd1 << s;
    tick();
    done_v = 4'd0;
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.abort    = 1'b0;
    bus.fc_class = 4'd0;
    #1 rst = 1'b1;
    #1 chk("reset", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

    // Minimum-latency run, class 7.
    bus.enable   = 1'b1;
    bus.fc_class = 4'd7;
    tick();
    for (int s = 0; s < 4; s++) stage_step(s, 0);
    r_exp = 4'd7;
    chk("done_min", 4'd0, 1'b0, 1'b1, 1'b0, 2'd3, 4'd7);

    // Enable held through DONE must not restart.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_hold", 4'd0, 1'b0, 1'b1, 1'b0, 2'd3, 4'd7);
    end
    bus.enable = 1'b0;
    tick();
    chk("idle_keep_result", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd7);

    // New run clears result; pool hangs -> watchdog.
    bus.enable = 1'b1;
    tick();
    r_exp = 4'd0;
    stage_step(0, 0);
    stage_step(1, 0);
    chk("pool_issue", 4'b0010, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("pool_wait%0d", i), 4'd0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0);
    end
    tick();
    chk("timeout", 4'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0);
    tick();
    chk("timeout_hold", 4'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0);
    bus.enable = 1'b0;
    tick();
    chk("err_clear", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

    // Relu done in WAIT cycle 16 is accepted.
    bus.enable   = 1'b1;
    bus.fc_class = 4'ha;
    tick();
    stage_step(0, 0);
    stage_step(1, 15);
    stage_step(2, 0);
    stage_step(3, 0);
    r_exp = 4'ha;
    chk("done_boundary", 4'd0, 1'b0, 1'b1, 1'b0, 2'd3, 4'ha);
    bus.enable = 1'b0;
    tick();

    // Abort during conv WAIT.
    bus.enable = 1'b1;
    tick();
    r_exp = 4'd0;
    chk("abort_issue", 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    tick();
    bus.abort  = 1'b1;
    bus.enable = 1'b0;
    tick();
    bus.abort = 1'b0;
    chk("abort_wait", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    tick();
    chk("abort_idle", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

    // Abort in ISSUE.
    bus.enable = 1'b1;
    tick();
    bus.abort  = 1'b1;
    bus.enable = 1'b0;
    tick();
    bus.abort = 1'b0;
    chk("abort_in_issue", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

    // Stray fc_done in conv stage, conv_done held three cycles.
    bus.enable   = 1'b1;
    bus.fc_class = 4'd3;
    tick();
    tick();
    done_v = 4'b1000;
    tick();
    chk("stray_fc", 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    done_v = 4'b0001;
    tick();
    chk("held_issue", 4'b0100, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0);
    tick();
    chk("held_wait1", 4'd0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0);
    tick();
    chk("held_wait2", 4'd0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0);
    done_v = 4'b0010;
    tick();
    done_v = 4'd0;
    bus.fc_class = 4'd5;
    stage_step(2, 0);
    stage_step(3, 0);
    chk("done_stray", 4'd0, 1'b0, 1'b1, 1'b0, 2'd3, 4'd5);
    bus.enable = 1'b0;
    tick();

    // Asynchronous reset during pool WAIT.
    bus.enable = 1'b1;
    tick();
    stage_step(0, 0);
    stage_step(1, 0);
    tick();
    chk("pre_reset", 4'd0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0);
    #2 rst = 1'b1;
    #1 chk("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    bus.enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
